scan_ctrl4: RTL

- Upstream driver for the 4-to-1 nibble selector in the 4-digit seven-segment display path.
- Holds four registered 4-bit digit values and presents them on oC0..oC3, which feed the selector's iC0..iC3.
- Runs a prescaled 2-bit scan index, presented on oS1/oS0, which drives the selector's select inputs.
- Generates active-low digit enables with inter-slot blanking (anti-ghosting) and optional leading-zero suppression.

---
 rtl/scan_ctrl4.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scan_ctrl4.sv
// ---------------------------------------------------------------------------
// scan_ctrl4 -- scan controller for a 4-digit multiplexed seven-segment display.
//
// Purpose:
//   Holds four registered BCD/hex digits and feeds them to a downstream 4-to-1
//   nibble selector. A prescaler divides iClk into digit slots of DIV cycles.
//   A 2-bit scan index advances once per slot and drives the selector selects.
//   The active-low digit enables are blanked for the first BLANK cycles of each
//   slot so the previous digit's segments do not ghost onto the next one.
//   Leading zeros can optionally be suppressed.
//
// Ports:
//   iClk          system clock, rising edge
//   iRst_n        asynchronous active-low reset
//   iEn           scan enable; when low the slot freezes and all digits are off
//   iLoad         capture strobe for iD0..iD3
//   iLzEn         leading-zero suppression enable
//   iD0..iD3      digit values (iD0 = least significant)
//   oC0..oC3      registered digits, to selector iC0..iC3
//   oS1, oS0      scan index bits, to selector iS1/iS0
//   oAn           active-low digit enables, bit k enables digit k
//   oTick         one-cycle pulse in the first cycle of each new slot
// ---------------------------------------------------------------------------
module scan_ctrl4 #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic       iLoad,
    input  logic       iLzEn,
    input  logic [3:0] iD0,
    input  logic [3:0] iD1,
    input  logic [3:0] iD2,
    input  logic [3:0] iD3,
    output logic [3:0] oC0,
    output logic [3:0] oC1,
    output logic [3:0] oC2,
    output logic [3:0] oC3,
    output logic       oS1,
    output logic       oS0,
    output logic [3:0] oAn,
    output logic       oTick
);

    // Prescaler width; at least one bit so DIV=2 still has a counter.
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
    localparam logic [CW-1:0] CntBlank = CW'(BLANK);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          r_tick;
    logic [3:0]    r_c0;
    logic [3:0]    r_c1;
    logic [3:0]    r_c2;
    logic [3:0]    r_c3;

    logic          w_z3;
    logic          w_z32;
    logic          w_z321;
    logic          w_sup;
    logic          w_lit;

    // -----------------------------------------------------------------------
    // State: prescaler, scan index, tick and digit registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt  <= '0;
            r_idx  <= 2'd0;
            r_tick <= 1'b0;
            r_c0   <= 4'd0;
            r_c1   <= 4'd0;
            r_c2   <= 4'd0;
            r_c3   <= 4'd0;
        end else begin
            if (iEn) begin
                if (r_cnt == CntLast) begin
                    r_cnt  <= '0;
                    r_idx  <= r_idx + 2'd1;  // 3 wraps to 0 naturally
                    r_tick <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end

            // Loading is independent of scanning and may coincide with an advance.
            if (iLoad) begin
                r_c0 <= iD0;
                r_c1 <= iD1;
                r_c2 <= iD2;
                r_c3 <= iD3;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero detection on the stored digits.
    // -----------------------------------------------------------------------
    assign w_z3   = (r_c3 == 4'd0);
    assign w_z32  = w_z3 && (r_c2 == 4'd0);
    assign w_z321 = w_z32 && (r_c1 == 4'd0);

    always_comb begin
        w_sup = 1'b0;
        unique case (r_idx)
            2'd3:    w_sup = iLzEn && w_z3;
            2'd2:    w_sup = iLzEn && w_z32;
            2'd1:    w_sup = iLzEn && w_z321;
            default: w_sup = 1'b0;  // digit 0 always shows
        endcase
    end

    // Digit is lit only outside the blanking window of an enabled slot.
    assign w_lit = iEn && (r_cnt >= CntBlank) && !w_sup;

    always_comb begin
        oAn = 4'b1111;
        if (w_lit) begin
            oAn[r_idx] = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    assign oC0   = r_c0;
    assign oC1   = r_c1;
    assign oC2   = r_c2;
    assign oC3   = r_c3;
    assign oS1   = r_idx[1];
    assign oS0   = r_idx[0];
    // Gated so a tick never appears while scanning is disabled.
    assign oTick = r_tick && iEn;

endmodule
